// File: rtl/uart_tx_if.sv
// Byte-request handshake between the packetizer FSM (master) and the UART transmitter (slave).
// tx_busy is partly combinational on start_tx so the master sees busy in its request cycle.
interface uart_tx_if;
    logic       start_tx;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overrun;

    modport master (
        output start_tx,
        output tx_data,
        input  tx_busy,
        input  tx_done,
        input  tx_overrun
    );

    modport slave (
        input  start_tx,
        input  tx_data,
        output tx_busy,
        output tx_done,
        output tx_overrun
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per start_tx strobe becomes an 8-bit asynchronous frame on tx,
// with optional parity and 1 or 2 stop bits; bit timing comes from an internal baud counter.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              stop_q, stop_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              tick_s;
    logic              accept_s;

    function automatic logic parity_f(input logic [7:0] byte_v, input logic odd_v);
        return (^byte_v) ^ odd_v;
    endfunction

    assign tick_s   = (baud_q == BAUD_LAST);
    assign accept_s = (state_q == S_IDLE) && bus.start_tx;

    assign tx             = tx_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_overrun = ovr_q;
    // Combinational start_tx term stops the upstream FSM issuing a second read on the accept edge.
    assign bus.tx_busy    = (state_q != S_IDLE) || bus.start_tx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transition except acceptance happens on a baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_tx) state_d = S_START;
                else              state_d = S_IDLE;
            end
            S_START: begin
                if (tick_s) state_d = S_DATA;
                else        state_d = S_START;
            end
            S_DATA: begin
                if (tick_s && (bit_q == 3'd7)) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                else                           state_d = S_DATA;
            end
            S_PARITY: begin
                if (tick_s) state_d = S_STOP;
                else        state_d = S_PARITY;
            end
            S_STOP: begin
                if (tick_s && (stop_q == STOP_LAST)) state_d = S_IDLE;
                else                                 state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; tx is precomputed from the next state so it leaves a flop.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        tx_d    = 1'b1;

        // Parity is taken from the byte as accepted, never from the shifting register.
        if (accept_s) begin
            baud_d  = {BAUD_W{1'b0}};
            bit_d   = 3'd0;
            shift_d = bus.tx_data;
            par_d   = parity_f(bus.tx_data, ODD_SEL);
            stop_d  = 1'b0;
        end else if ((state_q == S_IDLE) || tick_s) begin
            baud_d = {BAUD_W{1'b0}};
            if ((state_q == S_DATA) && tick_s) begin
                bit_d   = bit_q + 3'd1;
                shift_d = {1'b0, shift_q[7:1]};
            end else if ((state_q == S_STOP) && tick_s) begin
                stop_d = stop_q + 1'b1;
            end else begin
                bit_d = bit_q;
            end
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase

        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        ovr_d  = bus.start_tx && (state_q != S_IDLE);
    end

    // Datapath and output registers; reset forces the line high and drops any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q  <= {BAUD_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations at 4 clocks/bit; stimulus pushes hand-written frames
// into a scoreboard and per-instance monitors decode tx and compare against them.
module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_a = 4'd0;
    logic [7:0] data_a [4];
    wire  [3:0] tx_w, busy_w, done_w, ovr_w;
    logic [3:0] capt_a = 4'd0;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int done_cnt [4];
    int ovr_cnt [4];

    typedef struct {
        int          inst;
        logic [15:0] bits;     // first transmitted bit at index nb-1
        int          nb;
        int          t_start;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_u
        localparam int PE = (gi == 1 || gi == 2) ? 1 : 0;
        localparam int PO = (gi == 2) ? 1 : 0;
        localparam int SB = (gi == 3) ? 2 : 1;

        uart_tx_if bus ();

        assign bus.start_tx = start_a[gi];
        assign bus.tx_data  = data_a[gi];
        assign busy_w[gi]   = bus.tx_busy;
        assign done_w[gi]   = bus.tx_done;
        assign ovr_w[gi]    = bus.tx_overrun;

        uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus),
            .tx (tx_w[gi])
        );

        // Monitor: detect a start bit, sample every cycle of the frame, then expect tx_done.
        initial begin : mon
            exp_t     e;
            int       cnt;
            int       ferr;
            int       berr;
            bit       capt;
            logic [3:0] idx;
            capt = 1'b0; cnt = 0; ferr = 0; berr = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    capt = 1'b0;
                end else begin
                    if (done_w[gi] === 1'b1) done_cnt[gi]++;
                    if (ovr_w[gi] === 1'b1) ovr_cnt[gi]++;
                    if (!capt && tx_w[gi] === 1'b0) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_frame", 32'(sb.size()), 32'd1);
                        end else begin
                            e = sb.pop_front();
                            chk("frame_inst", 32'(e.inst), 32'(gi));
                            chk("start_latency", 32'(cyc), 32'(e.t_start));
                            capt = 1'b1; cnt = 0; ferr = 0; berr = 0;
                        end
                    end
                    if (capt) begin
                        if (cnt < e.nb * C) begin
                            idx = 4'(e.nb - 1 - cnt / C);
                            if (tx_w[gi] !== e.bits[idx]) ferr++;
                            if (busy_w[gi] !== 1'b1) berr++;
                            cnt++;
                        end else begin
                            chk("frame_bits", 32'(ferr), 32'd0);
                            chk("busy_span", 32'(berr), 32'd0);
                            chk("done_at_f_plus_1", 32'(done_w[gi]), 32'd1);
                            chk("tx_idle_at_done", 32'(tx_w[gi]), 32'd1);
                            capt = 1'b0;
                        end
                    end
                end
                capt_a[gi] = capt;
            end
        end
    end

    // Assumes the caller is just after a rising edge; that cycle becomes the request cycle N.
    task automatic issue(input int i, input logic [7:0] b, input logic [15:0] bits, input int nb);
        sb.push_back('{i, bits, nb, cyc + 1});
        start_a[i] = 1'b1;
        data_a[i]  = b;
        @(negedge clk);
        chk("busy_in_request_cycle", 32'(busy_w[i]), 32'd1);
        @(posedge clk);
        #1;
        start_a[i] = 1'b0;
        data_a[i]  = ~b;
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic [15:0] bits, input int nb);
        @(posedge clk);
        #1;
        issue(i, b, bits, nb);
    endtask

    task automatic wait_idle(input int i);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && capt_a[i] == 1'b0) break;
        end
        chk("wait_idle_timeout", 32'(k < 200), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad [4];
        int k;
        for (int i = 0; i < 4; i++) begin
            data_a[i] = 8'h00; done_cnt[i] = 0; ovr_cnt[i] = 0; bad[i] = 0;
        end

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_tx", 32'(tx_w[i]), 32'd1);
            chk("reset_busy", 32'(busy_w[i]), 32'd0);
            chk("reset_done", 32'(done_w[i]), 32'd0);
            chk("reset_overrun", 32'(ovr_w[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || ovr_w[i] !== 1'b0)
                    bad[i]++;
            end
        end
        for (int i = 0; i < 4; i++) chk("idle_100_cycles", 32'(bad[i]), 32'd0);

        send(0, 8'hA5, 16'b000000_0101001011, 10);
        wait_idle(0);
        send(1, 8'hA5, 16'b00000_01010010101, 11);
        wait_idle(1);
        send(2, 8'hA5, 16'b00000_01010010111, 11);
        wait_idle(2);
        send(1, 8'h07, 16'b00000_01110000011, 11);
        wait_idle(1);
        send(3, 8'h00, 16'b00000_00000000011, 11);
        wait_idle(3);

        // Overrun during DATA of 0x3C, then a back-to-back request in the tx_done cycle.
        send(0, 8'h3C, 16'b000000_0001111001, 10);
        repeat (10) @(posedge clk);
        #1;
        start_a[0] = 1'b1;
        data_a[0]  = 8'hFF;
        @(negedge clk);
        chk("busy_during_overrun", 32'(busy_w[0]), 32'd1);
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        @(negedge clk);
        chk("overrun_pulse", 32'(ovr_w[0]), 32'd1);
        @(negedge clk);
        chk("overrun_single", 32'(ovr_w[0]), 32'd0);
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done_w[0] === 1'b1) break;
        end
        chk("b2b_done_seen", 32'(done_w[0]), 32'd1);
        issue(0, 8'h81, 16'b000000_0100000011, 10);
        wait_idle(0);

        // Reset while data bit 4 of 0x00 is on the line.
        send(0, 8'h00, 16'b000000_0000000001, 10);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_tx_low", 32'(tx_w[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("reset_midframe_tx", 32'(tx_w[0]), 32'd1);
        chk("reset_midframe_busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt[0]), 32'd3);
        send(0, 8'h55, 16'b000000_0101010101, 10);
        wait_idle(0);

        chk("done_count_0", 32'(done_cnt[0]), 32'd4);
        chk("done_count_1", 32'(done_cnt[1]), 32'd2);
        chk("done_count_2", 32'(done_cnt[2]), 32'd1);
        chk("done_count_3", 32'(done_cnt[3]), 32'd1);
        chk("overrun_count_0", 32'(ovr_cnt[0]), 32'd1);
        chk("overrun_count_1", 32'(ovr_cnt[1]), 32'd0);
        chk("overrun_count_2", 32'(ovr_cnt[2]), 32'd0);
        chk("overrun_count_3", 32'(ovr_cnt[3]), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage that converts one byte per `start_tx` strobe into an asynchronous 8-bit UART frame on `tx`. It sits directly downstream of the packetizer FSM: it consumes that FSM's `start_tx`/`tx_data` and returns `tx_busy` to pace it. It generates its own bit-period timing from `clk`. Parity and stop-bit count are selectable at elaboration.

## Interface
- `CLKS_PER_BIT`, 868 — clk cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `PARITY_EN`, 0 — 1 inserts a parity bit after d7.
- `PARITY_ODD`, 0 — 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1 — 1 or 2 stop bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_tx`  in  1  single-cycle request to send `tx_data`.
- `tx_data`  in  8  byte to send; sampled in the cycle `start_tx`=1.
- `tx`  out  1  serial line, idles high.
- `tx_busy`  out  1  frame accepted or in progress.
- `tx_done`  out  1  one-cycle pulse at end of frame.
- `tx_overrun`  out  1  one-cycle pulse when `start_tx` arrives while busy.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. On `start_tx`=1, latch `tx_data` into the shift register, clear the bit counter and baud counter, and go to START.
- START: `tx`=0 for one bit period, then go to DATA.
- DATA: `tx` = shift register bit 0, LSB first. Shift right at the end of each bit period. After 8 bits, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY: `tx` = XOR of the latched byte, XORed with `PARITY_ODD`. The parity value is computed from the byte latched at acceptance, not from the shifted register. Hold for one bit period, then go to STOP.
- STOP: `tx`=1 for `STOP_BITS` bit periods. At the final baud tick, pulse `tx_done` and return to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. Counts 0..`CLKS_PER_BIT`-1. The tick occurs at terminal count; the counter wraps to 0 and restarts at every state change.
- Requests while busy are not queued:
  - `start_tx`=1 in any state other than IDLE is ignored. The frame in flight is unaffected.
  - `tx_overrun` pulses in the following cycle.
- `tx_busy` = (state ≠ IDLE) OR `start_tx`. The combinational term makes busy visible in the same cycle as the request. This prevents the upstream FSM, which returns to IDLE while `start_tx` is high, from issuing a second read on that edge.
- `tx_data` changes outside the accepting cycle have no effect.
- Reset mid-frame: the frame is abandoned. `tx` returns to 1 immediately, and there is no `tx_done`. This is legal: the line simply shows a truncated frame.

## Timing
- Reset values: `tx`=1, `tx_busy`=0 (with `start_tx`=0), `tx_done`=0, `tx_overrun`=0, state IDLE, all counters 0.
- `tx` is driven from a flop; there is no combinational path from inputs to `tx`.
- Request latency: with `start_tx` high in cycle N, the edge ending cycle N accepts it, and `tx` is 0 from cycle N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. There is no jitter and no fractional accumulation.
- Frame length F = (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, occupying cycles N+1..N+F.
- `tx_done` is high in cycle N+F+1, together with state IDLE and registered busy = 0.
- Back-to-back: `start_tx` may be asserted in the `tx_done` cycle and is accepted. The next start bit begins in the cycle after that, so idle high between frames is exactly 1 cycle minimum.
- `tx_overrun` is high exactly one cycle after each rejected `start_tx` cycle.

## Test plan
- Reset then idle for 100 cycles → `tx`=1, `tx_busy`=0, no `tx_done`/`tx_overrun` pulses.
- `CLKS_PER_BIT`=4, no parity, 1 stop bit; send 0xA5:
  - `tx` per 4-cycle bit reads 0,1,0,1,0,0,1,0,1,1 (40 cycles from N+1).
  - `tx_done` in cycle N+41.
  - `tx_busy` is high from cycle N through N+40.
- `PARITY_EN`=1: send 0xA5 with `PARITY_ODD`=0 → parity bit 0. With `PARITY_ODD`=1 → parity bit 1. Send 0x07 with even parity → parity bit 1. Each frame is 44 cycles.
- `STOP_BITS`=2, send 0x00 → start bit plus 8 data zeros (36 cycles low), then 8 cycles high before `tx_done`.
- Overrun: during the DATA state of 0x3C, pulse `start_tx` with 0xFF → `tx_overrun` pulses once, and the 0x3C frame completes bit-exact. Then drive `start_tx` with 0x81 in the `tx_done` cycle → accepted, start bit after a 1-cycle gap.
- Reset mid-frame at bit 4 → `tx`=1 and `tx_busy`=0 immediately. A fresh send of 0x55 afterward produces a correct frame.
